// File: rtl/bpsk_burst_controller.sv
// Push-button run/stop controller for the BPSK/QPSK transmit chain.
// Debounces the button, sequences sine warm-up and gates the modulator per symbol.
module bpsk_burst_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RST_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int BURST_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pb,
    input  logic               sine_rdy,
    input  logic               data_rdy,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               mode_sel,
    output logic               sine_rst,
    output logic               sine_clk_en,
    output logic               mod_en,
    output logic               mod_mode,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [BURST_W-1:0] sym_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PH_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] TO_LAST  = PH_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_WARM,
        S_RUN
    } state_e;

    state_e state_q, state_d;

    logic               sync1_q, sync2_q;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               pb_clean_q, pb_clean_d;
    logic               pb_prev_q;
    logic               press_q, press_d;

    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] sym_count_q, sym_count_d;
    logic [BURST_W-1:0] sym_inc;
    logic               mod_mode_q, mod_mode_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               accept;

    logic               sine_rst_q, sine_rst_d;
    logic               sine_clk_en_q, sine_clk_en_d;
    logic               mod_en_q, mod_en_d;
    logic               busy_q, busy_d;

    // Any sample that agrees with the clean level restarts the count.
    always_comb begin
        db_cnt_d   = '0;
        pb_clean_d = pb_clean_q;
        if (sync2_q != pb_clean_q) begin
            if (db_cnt_q == DB_LAST) begin
                pb_clean_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d = pb_clean_q & ~pb_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        len_d       = len_q;
        mod_mode_d  = mod_mode_q;
        sym_count_d = sym_count_q;
        err_d       = err_q;
        done_d      = 1'b0;
        accept      = 1'b0;
        sym_inc     = sym_count_q + 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    state_d     = S_PRIME;
                    len_d       = burst_len;
                    mod_mode_d  = mode_sel;
                    sym_count_d = '0;
                    err_d       = 1'b0;
                    phase_d     = '0;
                end
            end
            S_PRIME: begin
                if (press_q) begin
                    state_d = S_IDLE;
                end else if (phase_q == RST_LAST) begin
                    state_d = S_WARM;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_WARM: begin
                if (press_q) begin
                    state_d = S_IDLE;
                end else if (sine_rdy) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end else if (phase_q == TO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_RUN: begin
                if (press_q) begin
                    state_d = S_IDLE;
                end else if (data_rdy && sine_rdy) begin
                    accept = 1'b1;
                    if (sym_count_q != '1) begin
                        sym_count_d = sym_inc;
                    end
                    if ((len_q != '0) && (sym_inc == len_q)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        sine_rst_d    = (state_d == S_IDLE) || (state_d == S_PRIME);
        sine_clk_en_d = (state_d == S_WARM) || accept;
        mod_en_d      = accept;
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            pb_clean_q    <= 1'b0;
            pb_prev_q     <= 1'b0;
            press_q       <= 1'b0;
            phase_q       <= '0;
            len_q         <= '0;
            sym_count_q   <= '0;
            mod_mode_q    <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            sine_rst_q    <= 1'b1;
            sine_clk_en_q <= 1'b0;
            mod_en_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync1_q       <= pb;
            sync2_q       <= sync1_q;
            db_cnt_q      <= db_cnt_d;
            pb_clean_q    <= pb_clean_d;
            pb_prev_q     <= pb_clean_q;
            press_q       <= press_d;
            phase_q       <= phase_d;
            len_q         <= len_d;
            sym_count_q   <= sym_count_d;
            mod_mode_q    <= mod_mode_d;
            err_q         <= err_d;
            done_q        <= done_d;
            sine_rst_q    <= sine_rst_d;
            sine_clk_en_q <= sine_clk_en_d;
            mod_en_q      <= mod_en_d;
            busy_q        <= busy_d;
        end
    end

    assign sine_rst    = sine_rst_q;
    assign sine_clk_en = sine_clk_en_q;
    assign mod_en      = mod_en_q;
    assign mod_mode    = mod_mode_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign sym_count   = sym_count_q;

endmodule
